// File: rtl/mux_pkg.sv
// Shared types and constants for the round-robin stream mux front end.
//   sel_t           : mux select / grant / priority state encoding (0 = A, 1 = B)
//   CNT_W_DEFAULT   : default width of the per-channel beat counters
//   sat_value()     : all-ones saturation value for a counter of a given width
//   CNT_SAT_DEFAULT : saturation value at the default counter width
package mux_pkg;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_t;

    localparam int unsigned CNT_W_DEFAULT = 4;

    // Valid for widths below 32.
    function automatic int unsigned sat_value(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    localparam int unsigned CNT_SAT_DEFAULT = sat_value(CNT_W_DEFAULT);

    function automatic sel_t sel_other(input sel_t s);
        return (s == SEL_A) ? SEL_B : SEL_A;
    endfunction

endpackage

// File: rtl/mux2x1.sv
// Single-bit 2:1 multiplexer cell.
//   a, b : data inputs
//   sel  : 0 selects a, 1 selects b
//   y    : selected output
module mux2x1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/rr_grant2.sv
// Combinational two-way round-robin grant.
//   a_valid, b_valid : requests from channels A and B
//   pri              : channel that wins when both request
//   can_load         : output register can accept a beat this cycle
//   grant            : selected channel (meaningful only with grant_en)
//   grant_en         : a handshake happens on the granted channel
module rr_grant2
    import mux_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
    input  sel_t pri,
    input  logic can_load,
    output sel_t grant,
    output logic grant_en
);

    always_comb begin
        grant    = SEL_A;
        grant_en = 1'b0;
        if (a_valid && b_valid) begin
            grant    = pri;
            grant_en = can_load;
        end else if (a_valid) begin
            grant    = SEL_A;
            grant_en = can_load;
        end else if (b_valid) begin
            grant    = SEL_B;
            grant_en = can_load;
        end
    end

endmodule

// File: rtl/rr_stream_mux2.sv
// Round-robin arbiter of two valid/ready streams onto one registered output.
//   clk, rst            : clock and synchronous active-high reset
//   a_valid/a_data/a_ready : channel A input stream
//   b_valid/b_data/b_ready : channel B input stream
//   out_valid/out_data/out_ready : registered output stream
//   out_sel             : source of the current output beat (0 = A, 1 = B)
//   cnt_a, cnt_b        : saturating accepted-beat counters per channel
module rr_stream_mux2
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam logic [CNT_W-1:0] CntSat = CNT_W'(sat_value(CNT_W));

    sel_t             pri_q, pri_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    sel_t             out_sel_q, out_sel_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    logic             can_load;
    sel_t             grant;
    logic             grant_en;
    logic             take;
    logic [WIDTH-1:0] mux_y;

    // Register may load when empty or when its beat leaves this cycle.
    assign can_load = !out_valid_q || out_ready;

    rr_grant2 u_grant (
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .pri      (pri_q),
        .can_load (can_load),
        .grant    (grant),
        .grant_en (grant_en)
    );

    // Suppress the handshake during reset so no beat is accepted then lost.
    assign take    = grant_en && !rst;
    assign a_ready = take && (grant == SEL_A);
    assign b_ready = take && (grant == SEL_B);

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux2x1 u_mux (
            .a   (a_data[i]),
            .b   (b_data[i]),
            .sel (grant),
            .y   (mux_y[i])
        );
    end

    always_comb begin
        pri_d       = pri_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_y;
            out_sel_d   = grant;
            pri_d       = sel_other(grant);
            if (grant == SEL_A) begin
                if (cnt_a_q != CntSat) cnt_a_d = cnt_a_q + CNT_W'(1);
            end else begin
                if (cnt_b_q != CntSat) cnt_b_d = cnt_b_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            // Drained with nothing to refill; payload keeps its last value.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q       <= SEL_A;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= SEL_A;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
        end else begin
            pri_q       <= pri_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign cnt_a     = cnt_a_q;
    assign cnt_b     = cnt_b_q;

endmodule

// File: tb/tb_rr_stream_mux2.sv
// Self-checking bench for rr_stream_mux2: reference model plus output scoreboard.
module tb_rr_stream_mux2;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = 15;

    logic             clk;
    logic             rst;
    logic             a_valid, b_valid;
    logic [WIDTH-1:0] a_data, b_data;
    logic             a_ready, b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_ready;
    logic [CNT_W-1:0] cnt_a, cnt_b;

    rr_stream_mux2 #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state, reflecting the DUT after the most recent clock edge.
    logic             m_pri;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_sel;
    int               m_ca, m_cb;
    logic [WIDTH:0]   sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic av, input logic [WIDTH-1:0] ad, input logic bv,
                         input logic [WIDTH-1:0] bd, input logic ordy, input logic r);
        logic           can, ga, gb, ea, eb;
        logic [WIDTH:0] beat;
        @(negedge clk);
        a_valid   = av;
        a_data    = ad;
        b_valid   = bv;
        b_data    = bd;
        out_ready = ordy;
        rst       = r;
        #1;
        can = !m_valid || ordy;
        ga  = av && (!bv || m_pri == 1'b0);
        gb  = bv && (!av || m_pri == 1'b1);
        ea  = !r && can && ga;
        eb  = !r && can && gb;
        check_eq("a_ready", 32'(a_ready), 32'(ea));
        check_eq("b_ready", 32'(b_ready), 32'(eb));
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_data", 32'(out_data), 32'(m_data));
        check_eq("out_sel", 32'(out_sel), 32'(m_sel));
        check_eq("cnt_a", 32'(cnt_a), 32'(m_ca));
        check_eq("cnt_b", 32'(cnt_b), 32'(m_cb));
        if (r) begin
            sb.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 1'b0;
            m_pri   = 1'b0;
            m_ca    = 0;
            m_cb    = 0;
        end else begin
            if (m_valid && ordy) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 32'd1, 32'd0);
                end else begin
                    beat = sb.pop_front();
                    check_eq("beat_data", 32'(out_data), 32'(beat[WIDTH-1:0]));
                    check_eq("beat_sel", 32'(out_sel), 32'(beat[WIDTH]));
                end
            end
            if (ea || eb) begin
                m_valid = 1'b1;
                m_sel   = eb;
                m_data  = eb ? bd : ad;
                sb.push_back({eb, m_data});
                m_pri   = eb ? 1'b0 : 1'b1;
                if (ea && m_ca < CMAX) m_ca++;
                if (eb && m_cb < CMAX) m_cb++;
            end else if (ordy) begin
                m_valid = 1'b0;
            end
        end
    endtask

    initial begin
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        a_data    = 8'h11;
        b_data    = 8'h22;
        out_ready = 1'b1;
        rst       = 1'b1;
        m_pri     = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_sel     = 1'b0;
        m_ca      = 0;
        m_cb      = 0;
        // Unchecked edge brings the DUT out of X.
        @(posedge clk);

        // Reset held two cycles with both producers valid.
        repeat (2) cycle(1, 8'h11, 1, 8'h22, 1, 1);

        // Alternation, then backpressure while holding an A beat.
        repeat (5) cycle(1, 8'h11, 1, 8'h22, 1, 0);
        repeat (3) cycle(1, 8'h11, 1, 8'h22, 0, 0);
        repeat (2) cycle(1, 8'h11, 1, 8'h22, 1, 0);
        repeat (3) cycle(0, 8'h00, 0, 8'h00, 1, 0);

        // B only, back to back.
        for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1, 8'(8'h30 + i), 1, 0);
        repeat (2) cycle(0, 8'h00, 0, 8'h00, 1, 0);

        // Saturation of the A counter.
        cycle(0, 8'h00, 0, 8'h00, 1, 1);
        for (int i = 0; i < 20; i++) cycle(1, 8'(8'h40 + i), 0, 8'h00, 1, 0);
        repeat (2) cycle(0, 8'h00, 0, 8'h00, 1, 0);

        // Reset while a beat is in flight and both are valid.
        repeat (3) cycle(1, 8'h5a, 1, 8'ha5, 1, 0);
        cycle(1, 8'h5a, 1, 8'ha5, 1, 1);
        repeat (3) cycle(1, 8'h66, 1, 8'h77, 1, 0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
        end
        repeat (3) cycle(0, 8'h00, 0, 8'h00, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux2.md
Name: rr_stream_mux2

Overview:
- Sequential front end for the team's mux2x1 cell. Arbitrates two valid/ready input streams, A and B, onto one registered output stream.
- Generates the mux select with round-robin fairness.
- Keeps a saturating beat count per channel for debug and coverage.
- Sits between two producers and a single downstream consumer. Drives `sel` for the data-path mux.

Parameters:
- WIDTH, 8: data width of each input stream and of the output stream.
- CNT_W, 4: width of each per-channel saturating beat counter.

Ports:
- clk  input  1  rising-edge clock; the block uses this single clock only.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  channel A beat available.
- a_data  input  WIDTH  channel A payload.
- a_ready  output  1  channel A beat accepted this cycle.
- b_valid  input  1  channel B beat available.
- b_data  input  WIDTH  channel B payload.
- b_ready  output  1  channel B beat accepted this cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered payload.
- out_sel  output  1  source of the current output beat; 0 = A, 1 = B.
- out_ready  input  1  consumer accepts the output beat.
- cnt_a  output  CNT_W  beats accepted from A; saturating.
- cnt_b  output  CNT_W  beats accepted from B; saturating.

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_sel=0, cnt_a=0, cnt_b=0, priority state=PRI_A.
- Reset mid-operation: an in-flight beat is dropped. No ready is asserted in the reset cycle.
- Priority FSM:
  - States: PRI_A (A wins a tie) and PRI_B (B wins a tie).
  - After a grant to A, the next state is PRI_B. After a grant to B, the next state is PRI_A.
  - With no grant, the state holds.
- Load condition: can_load = !out_valid || out_ready, evaluated combinationally.
- Grant, combinational:
  - If both inputs are valid, grant the channel the priority state favours.
  - If only one input is valid, grant that channel.
  - If neither is valid, no grant.
- Ready outputs: a_ready = can_load && grant==A; b_ready likewise for B. Never both high in the same cycle.
  - Ready may depend on the other channel's valid.
  - Ready must never depend on the same channel's data.
- On a grant (handshake):
  - out_data is loaded with the granted data, selected through WIDTH instances of mux2x1 with sel = grant.
  - out_sel is loaded with grant; out_valid is set to 1.
- Latency: one cycle from input handshake to out_valid.
- Throughput: one beat per cycle when out_ready is held high (simultaneous drain and refill).
- Output held: out_valid=1 && out_ready=0 gives both readies = 0. out_data and out_sel are held stable.
- Drain with no input: out_valid && out_ready with no grant clears out_valid to 0. out_data keeps its last value.
- Counters: cnt_a increments on an A handshake and saturates at 2^CNT_W-1 with no wrap; cnt_b likewise for B. Reset is the only clear.
- Inputs are sampled only on a handshake. Data on a non-granted channel is ignored and must be held by its producer (standard valid/ready rule).

Decomposition:
- Package mux_pkg:
  - typedef enum logic {SEL_A=1'b0, SEL_B=1'b1} sel_t, used for grant, out_sel and the priority state.
  - localparam for the counter saturation value.
- Sub-module rr_grant2 (combinational): inputs a_valid, b_valid, priority state, can_load; outputs grant and grant_en.
- Data-path selection reuses mux2x1 in a generate loop over WIDTH. No new mux module.

Test Plan:
- Reset: assert rst for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, out_valid=0, cnt_a=cnt_b=0; first grant after release goes to A.
- Alternation: both valid continuously, a_data=8'h11, b_data=8'h22, out_ready=1 -> out_data sequence 11,22,11,22 with out_sel 0,1,0,1; cnt_a=cnt_b=2 after 4 beats.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 holding 8'h11 -> readies = 0, out_data stays 11; on out_ready=1 the next beat is B, 8'h22, in the following cycle.
- Single channel: only b_valid=1 for 5 cycles, out_ready=1 -> five B beats back-to-back, out_sel=1; cnt_b=5, cnt_a=0.
- Saturation: 20 A-only handshakes with CNT_W=4 -> cnt_a=15 and holds at 15.
- Mid-operation reset: rst asserted while out_valid=1 and both valid -> next cycle out_valid=0, counters 0, state PRI_A; no ready during the rst cycle.
